// File: rtl/ca_rule_engine.sv
// -----------------------------------------------------------------------------
// ca_rule_engine
//
// Generates successive rows of a one-dimensional elementary cellular automaton
// and writes each one into the frame buffer. A row pointer advances on every
// write and wraps at the bottom of the buffer region. The first action after
// reset is to write the seed row (a single live cell) to row 0.
//
// One new generation is computed serially, one cell per clock, from the
// current generation `cur` into `nxt`. `nxt` drives the write data directly,
// so address and data are registered and stay stable while the write waits
// for a slot.
//
// Parameters
//   CELLS    - cells per row, also the width of wr_data
//   ROWS     - rows in the frame buffer region; the row pointer wraps at ROWS-1
//   SEED_POS - index of the single live cell in the seed row
//   WRAP     - 1: toroidal neighbours, 0: cells outside the row read as 0
//
// Ports
//   clk          in   system clock, all logic on the rising edge
//   rst          in   synchronous, active-low reset
//   step         in   one-cycle request for the next generation
//   rule         in   [7:0] Wolfram rule number, latched on an accepted step
//   init_rdy     in   frame buffer initialisation complete
//   wr_ok        in   write slot available (display blanking)
//   wr_en        out  frame buffer write strobe (one cycle per generation)
//   wr_addr      out  [6:0] row address
//   wr_data      out  [0:CELLS-1] row data, bit 0 is the leftmost cell
//   busy         out  high whenever the engine is not idle
//   rows_written out  [15:0] number of completed writes, wraps modulo 2^16
// -----------------------------------------------------------------------------
module ca_rule_engine #(
   parameter int CELLS    = 100,
   parameter int ROWS     = 75,
   parameter int SEED_POS = 50,
   parameter int WRAP     = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             step,
   input  logic [7:0]       rule,
   input  logic             init_rdy,
   input  logic             wr_ok,
   output logic             wr_en,
   output logic [6:0]       wr_addr,
   output logic [0:CELLS-1] wr_data,
   output logic             busy,
   output logic [15:0]      rows_written
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CALC    = 2'd1,
      WAIT_WR = 2'd2
   } state_t;

   // Seed row: only cell SEED_POS alive. With the [0:CELLS-1] ordering bit 0
   // is the MSB, so shifting right moves the live cell to higher indices.
   localparam logic [0:CELLS-1] SEED     = {1'b1, {(CELLS-1){1'b0}}} >> SEED_POS;
   localparam logic [6:0]       LAST_IDX = 7'(CELLS - 1);
   localparam logic [6:0]       LAST_ROW = 7'(ROWS - 1);

   state_t           state_q;
   state_t           state_d;
   logic [0:CELLS-1] cur;
   logic [0:CELLS-1] nxt;
   logic [7:0]       rule_q;
   logic [6:0]       idx;
   logic [6:0]       row_ptr;
   logic [15:0]      rows_cnt;

   logic             l_bit;
   logic             c_bit;
   logic             r_bit;
   logic             write_now;

   // --------------------------------------------------------------------------
   // Neighbourhood of the cell currently being computed. The ends of the row
   // either wrap around to the opposite edge or read as a dead cell.
   // --------------------------------------------------------------------------
   // NOTE: every signal assigned in an always_comb block gets a default at the
   // top, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      l_bit = 1'b0;
      r_bit = 1'b0;
      c_bit = cur[idx];

      if (idx == 7'd0) begin
         l_bit = (WRAP != 0) ? cur[CELLS-1] : 1'b0;
      end else begin
         l_bit = cur[idx - 7'd1];
      end

      if (idx == LAST_IDX) begin
         r_bit = (WRAP != 0) ? cur[0] : 1'b0;
      end else begin
         r_bit = cur[idx + 7'd1];
      end
   end

   // --------------------------------------------------------------------------
   // Write strobe. Combinational so the write lands in the very cycle a slot
   // opens; gated by rst so nothing is written while reset is asserted.
   // --------------------------------------------------------------------------
   always_comb begin
      write_now = 1'b0;
      if ((state_q == WAIT_WR) && wr_ok && init_rdy && rst) begin
         write_now = 1'b1;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic.
   // --------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (step) begin
               state_d = CALC;
            end
         end
         CALC: begin
            if (idx == LAST_IDX) begin
               state_d = WAIT_WR;
            end
         end
         WAIT_WR: begin
            if (write_now) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = WAIT_WR;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // State register and datapath.
   //
   // Reset puts the engine straight into WAIT_WR with the seed in both row
   // registers, so the seed row is the first thing written, at address 0.
   // Reset takes effect from any state, which discards a partially computed
   // row without writing it.
   // --------------------------------------------------------------------------
   // NOTE: state is updated with non-blocking assignments so every register
   // samples the values from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= WAIT_WR;
         // NOTE: the row registers are plain flops, not a RAM, and must hold a
         // defined seed after reset, so they are reset like any other state.
         cur      <= SEED;
         nxt      <= SEED;
         rule_q   <= 8'd0;
         idx      <= 7'd0;
         row_ptr  <= 7'd0;
         rows_cnt <= 16'd0;
      end else begin
         state_q <= state_d;

         case (state_q)
            IDLE: begin
               // Rule is captured once per generation; later switch changes
               // wait for the next step.
               if (step) begin
                  rule_q <= rule;
                  idx    <= 7'd0;
               end
            end

            CALC: begin
               // {L,C,R} selects one bit of the rule, L being the MSB.
               nxt[idx] <= rule_q[{l_bit, c_bit, r_bit}];
               if (idx != LAST_IDX) begin
                  idx <= idx + 7'd1;
               end
            end

            WAIT_WR: begin
               if (write_now) begin
                  cur      <= nxt;
                  row_ptr  <= (row_ptr == LAST_ROW) ? 7'd0 : row_ptr + 7'd1;
                  rows_cnt <= rows_cnt + 16'd1;
               end
            end

            default: begin
            end
         endcase
      end
   end

   assign wr_en        = write_now;
   assign wr_addr      = row_ptr;
   assign wr_data      = nxt;
   assign busy         = (state_q != IDLE);
   assign rows_written = rows_cnt;

endmodule

// File: tb/tb_ca_rule_engine.sv
// -----------------------------------------------------------------------------
// tb_ca_rule_engine
//
// Three engines share clock, reset, rule and write-slot inputs:
//   dut 0 : default parameters (seed at 50, wrap on), driven by step_m
//   dut 1 : seed at 0, wrap on,  driven by step_e
//   dut 2 : seed at 0, wrap off, driven by step_e
// Stimulus pushes the expected write (address, data, rows_written at the
// moment of the write) into a per-engine queue; a monitor pops and compares
// whenever an engine asserts wr_en.
// -----------------------------------------------------------------------------
module tb_ca_rule_engine;

   typedef struct {
      logic [6:0]  addr;
      logic [0:99] data;
      logic [15:0] rw;
   } exp_t;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic        rst;
   logic        step_m;
   logic        step_e;
   logic [7:0]  rule;
   logic        init_rdy;
   logic        wr_ok;

   logic [2:0]             wr_en_v;
   logic [2:0][6:0]        addr_v;
   logic [2:0][0:99]       data_v;
   logic [2:0]             busy_v;
   logic [2:0][15:0]       rw_v;

   exp_t        q[3][$];
   int          ptr[3];
   int          wr_cnt[3];
   logic [6:0]  last_addr[3];
   logic [0:99] cur_m;

   int n_checks = 0;
   int n_fail   = 0;

   ca_rule_engine u_main (
      .clk(clk), .rst(rst), .step(step_m), .rule(rule), .init_rdy(init_rdy),
      .wr_ok(wr_ok), .wr_en(wr_en_v[0]), .wr_addr(addr_v[0]), .wr_data(data_v[0]),
      .busy(busy_v[0]), .rows_written(rw_v[0])
   );

   ca_rule_engine #(.SEED_POS(0), .WRAP(1)) u_edge_wrap (
      .clk(clk), .rst(rst), .step(step_e), .rule(rule), .init_rdy(init_rdy),
      .wr_ok(wr_ok), .wr_en(wr_en_v[1]), .wr_addr(addr_v[1]), .wr_data(data_v[1]),
      .busy(busy_v[1]), .rows_written(rw_v[1])
   );

   ca_rule_engine #(.SEED_POS(0), .WRAP(0)) u_edge_flat (
      .clk(clk), .rst(rst), .step(step_e), .rule(rule), .init_rdy(init_rdy),
      .wr_ok(wr_ok), .wr_en(wr_en_v[2]), .wr_addr(addr_v[2]), .wr_data(data_v[2]),
      .busy(busy_v[2]), .rows_written(rw_v[2])
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [0:99] row_bits(input int a, input int b);
      logic [0:99] v;
      v = '0;
      if (a >= 0) v[a] = 1'b1;
      if (b >= 0) v[b] = 1'b1;
      return v;
   endfunction

   // Whole-row reference step with toroidal neighbours.
   function automatic logic [0:99] ca_next(input logic [0:99] r, input logic [7:0] ru);
      logic [0:99] n;
      logic [2:0]  k;
      n = '0;
      for (int i = 0; i < 100; i++) begin
         k[2] = r[(i + 99) % 100];
         k[1] = r[i];
         k[0] = r[(i + 1) % 100];
         n[i] = ru[k];
      end
      return n;
   endfunction

   task automatic push(input int d, input logic [0:99] data);
      exp_t e;
      e.addr = 7'(ptr[d]);
      e.data = data;
      e.rw   = 16'(wr_cnt[d]);
      q[d].push_back(e);
      ptr[d]    = (ptr[d] == 74) ? 0 : ptr[d] + 1;
      wr_cnt[d] = wr_cnt[d] + 1;
   endtask

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         ptr[d]    = 0;
         wr_cnt[d] = 0;
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_m();
      step_m = 1'b1;
      tick(1);
      step_m = 1'b0;
   endtask

   task automatic pulse_e();
      step_e = 1'b1;
      tick(1);
      step_e = 1'b0;
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      check(name, 128'(q[0].size() + q[1].size() + q[2].size()), 128'd0);
      tick(2);
   endtask

   // Scoreboard monitor: compares every write against the oldest expectation.
   always @(negedge clk) begin : monitor
      exp_t e;
      for (int d = 0; d < 3; d++) begin
         if (wr_en_v[d] === 1'b1) begin
            if (q[d].size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_write dut%0d: got write at addr %0d, expected no write",
                        d, addr_v[d]);
            end else begin
               e = q[d].pop_front();
               check($sformatf("wr_addr dut%0d", d), 128'(addr_v[d]), 128'(e.addr));
               check($sformatf("wr_data dut%0d", d), 128'(data_v[d]), 128'(e.data));
               check($sformatf("rows_written_at_write dut%0d", d), 128'(rw_v[d]), 128'(e.rw));
               last_addr[d] = addr_v[d];
            end
         end
      end
   end

   initial begin : watchdog
      #3ms;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

   logic [7:0] rules_tbl [6];
   logic [0:99] seed50;
   logic [0:99] seed0;

   initial begin : stim
      int n;
      int wcount;
      int k;

      rules_tbl = '{8'd1, 8'd30, 8'd90, 8'd110, 8'd150, 8'd45};
      seed50    = row_bits(50, -1);
      seed0     = row_bits(0, -1);

      rst      = 1'b0;
      step_m   = 1'b0;
      step_e   = 1'b0;
      rule     = 8'd0;
      init_rdy = 1'b1;
      wr_ok    = 1'b1;
      model_reset();
      tick(2);

      // ---- Reset state ----
      check("reset_wr_en",        128'(wr_en_v[0]), 128'd0);
      check("reset_wr_addr",      128'(addr_v[0]),  128'd0);
      check("reset_wr_data",      128'(data_v[0]),  128'(seed50));
      check("reset_busy",         128'(busy_v[0]),  128'd1);
      check("reset_rows_written", 128'(rw_v[0]),    128'd0);
      check("reset_wr_data_edge", 128'(data_v[1]),  128'(seed0));

      // ---- 1. Seed write right after reset release ----
      push(0, seed50);
      push(1, seed0);
      push(2, seed0);
      rst = 1'b1;
      drain("seed_write_drain", 20);
      check("after_seed_busy",         128'(busy_v[0]), 128'd0);
      check("after_seed_rows_written", 128'(rw_v[0]),   128'd1);

      // ---- 2. Rule 90, latency and two generations; rule 0 and 255 ----
      rule = 8'd90;
      push(0, row_bits(49, 51));
      pulse_m();
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (wr_en_v[0] !== 1'b1 && n < 500);
      check("step_to_wr_en_latency", 128'(n), 128'd101);
      tick(2);
      drain("rule90_gen1_drain", 20);

      push(0, row_bits(48, 52));
      pulse_m();
      drain("rule90_gen2_drain", 200);

      rule = 8'd0;
      push(0, '0);
      pulse_m();
      drain("rule0_drain", 200);

      rule = 8'd255;
      push(0, '1);
      pulse_m();
      drain("rule255_drain", 200);
      cur_m = '1;

      // ---- 3. Edge handling with seed at cell 0 ----
      rule = 8'd90;
      push(1, row_bits(1, 99));
      push(2, row_bits(1, -1));
      pulse_e();
      drain("edge_drain", 200);

      // ---- 4. Write gating; late rule change and a stray step are ignored ----
      wr_ok = 1'b0;
      rule  = 8'd90;
      push(0, '0);            // rule 90 on an all-ones row gives all zeros
      pulse_m();
      rule = 8'd255;
      tick(101);
      wcount = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (wr_en_v[0] === 1'b1) wcount++;
         step_m = (i == 150);
      end
      step_m = 1'b0;
      check("gated_no_wr_en", 128'(wcount), 128'd0);
      check("gated_busy",     128'(busy_v[0]), 128'd1);
      check("gated_pending",  128'(q[0].size()), 128'd1);
      tick(1);
      init_rdy = 1'b0;
      wr_ok    = 1'b1;
      wcount   = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (wr_en_v[0] === 1'b1) wcount++;
      end
      check("init_rdy_low_no_wr_en", 128'(wcount), 128'd0);
      tick(1);
      init_rdy = 1'b1;
      drain("gated_release_drain", 20);
      tick(150);
      check("gated_after_busy",         128'(busy_v[0]), 128'd0);
      check("gated_after_rows_written", 128'(rw_v[0]),   128'd6);
      cur_m = '0;

      // ---- 5. Row pointer wrap ----
      k = 0;
      while (wr_cnt[0] < 76) begin
         rule  = rules_tbl[k % 6];
         cur_m = ca_next(cur_m, rules_tbl[k % 6]);
         push(0, cur_m);
         pulse_m();
         drain($sformatf("wrap_step%0d_drain", k), 200);
         k++;
      end
      check("wrap_last_addr",     128'(last_addr[0]), 128'd0);
      check("wrap_rows_written",  128'(rw_v[0]),      128'd76);
      check("wrap_next_addr",     128'(addr_v[0]),    128'd1);

      // ---- 6. Reset in the middle of CALC ----
      rule = 8'd30;
      pulse_m();
      tick(40);
      rst = 1'b0;             // sampled with idx = 40
      tick(1);
      check("midcalc_reset_wr_en",   128'(wr_en_v[0]), 128'd0);
      check("midcalc_reset_addr",    128'(addr_v[0]),  128'd0);
      check("midcalc_reset_data",    128'(data_v[0]),  128'(seed50));
      check("midcalc_reset_busy",    128'(busy_v[0]),  128'd1);
      check("midcalc_reset_rows",    128'(rw_v[0]),    128'd0);
      model_reset();
      push(0, seed50);
      push(1, seed0);
      push(2, seed0);
      rst = 1'b1;
      drain("midcalc_seed_drain", 20);
      tick(150);
      check("midcalc_after_rows", 128'(rw_v[0]),   128'd1);
      check("midcalc_after_busy", 128'(busy_v[0]), 128'd0);

      for (int d = 0; d < 3; d++) begin
         check($sformatf("final_queue_empty dut%0d", d), 128'(q[d].size()), 128'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
